// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller for the chicken-crossing VGA game.
// Sequences IDLE -> PLAY -> HIT -> (PLAY | OVER) -> IDLE, synchronizes the
// player button, derives a frame tick from vsync and drives the scroll
// datapath controls.
// Build option: define GAME_CTRL_LIVES_EN to keep a lives counter; without it
// the lives register is removed, lives reads 0 and every hit ends the game.
module game_ctrl #(
  parameter int HIT_FRAMES = 60,
  parameter int LIVES      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       move_btn,
  input  logic       collision,
  output logic       play_rst,
  output logic       move_pulse,
  output logic       freeze,
  output logic       flash,
  output logic [1:0] lives,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HIT  = 2'b10,
    OVER = 2'b11
  } state_t;

  localparam logic [7:0] HIT_LAST = 8'(HIT_FRAMES);

  state_t     cur;
  logic       btn_s1;
  logic       btn_s2;
  logic       btn_s3;
  logic       btn_rise;
  logic       vs_q1;
  logic       vs_q2;
  logic       frame_tick;
  logic [7:0] frame_cnt;
  logic [7:0] frame_nxt;
  logic       last_life;

`ifdef GAME_CTRL_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  logic [1:0] lives_q;
  logic [1:0] lives_dec;

  assign lives_dec = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
  assign last_life = (lives_q == 2'd0);
  assign lives     = lives_q;
`else
  assign last_life = 1'b1;
  assign lives     = 2'b00;
`endif

  // Two-flop synchronizer for the raw button, plus an edge flop and a registered rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_s3   <= 1'b0;
      btn_rise <= 1'b0;
    end else begin
      btn_s1   <= move_btn;
      btn_s2   <= btn_s1;
      btn_s3   <= btn_s2;
      btn_rise <= btn_s2 & ~btn_s3;
    end
  end

  // Register vsync twice so the frame tick is a clean falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q1 <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      vs_q1 <= vsync;
      vs_q2 <= vs_q1;
    end
  end

  assign frame_tick = vs_q2 & ~vs_q1;
  assign frame_nxt  = frame_cnt + 8'd1;
  assign state      = cur;
  assign move_pulse = btn_rise & (cur == PLAY) & ~collision;

  // Game FSM with registered datapath controls, frame counter and lives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= IDLE;
      play_rst  <= 1'b1;
      freeze    <= 1'b0;
      flash     <= 1'b0;
      frame_cnt <= 8'd0;
`ifdef GAME_CTRL_LIVES_EN
      lives_q   <= 2'd0;
`endif
    end else begin
      case (cur)
        IDLE: begin
          if (btn_rise) begin
            cur      <= PLAY;
            play_rst <= 1'b0;
`ifdef GAME_CTRL_LIVES_EN
            lives_q  <= LIVES_INIT;
`endif
          end
        end
        PLAY: begin
          play_rst <= 1'b0;
          if (collision) begin
            cur       <= HIT;
            freeze    <= 1'b1;
            flash     <= 1'b0;
            frame_cnt <= 8'd0;
`ifdef GAME_CTRL_LIVES_EN
            lives_q   <= lives_dec;
`endif
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (frame_nxt == HIT_LAST) begin
              frame_cnt <= 8'd0;
              flash     <= 1'b0;
              play_rst  <= 1'b1;
              if (last_life) begin
                cur <= OVER;
              end else begin
                cur    <= PLAY;
                freeze <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_nxt;
              flash     <= frame_nxt[3];
            end
          end
        end
        OVER: begin
          if (btn_rise) begin
            cur      <= IDLE;
            freeze   <= 1'b0;
            play_rst <= 1'b1;
          end
        end
        default: begin
          cur <= IDLE;
        end
      endcase
    end
  end

endmodule
